mux_bus_ctrl: RTL and testbench
===============================

# mux_bus_ctrl

Parametrised controller for the CPU's multiplexed address/data bus, replacing hard-wired ALE/OE/WE sequencing in the machine model. It accepts one transaction at a time from the core over a valid/ready handshake. It then runs the external cycle (address latch phase, data phase, recovery) with programmable wait states, a one-hot chip-select decode and byte enables. It sits between the core and the external latches, transceivers and SRAMs.

## Interface
- AW, 20, total address width; must be greater than DW
- DW, 16, data/AD bus width; multiple of 8
- NCS, 8, number of chip selects; power of two, at least 2
- WAIT_CYC, 1, extra data-phase cycles (0..15)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller idle and able to accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  transaction address
- req_wdata  in  DW  write data
- req_be  in  DW/8  byte enables, active high
- rsp_valid  out  1  one-cycle pulse; read data valid or write done
- rsp_rdata  out  DW  read data, held until the next response
- ad_o  out  DW  AD bus drive value
- ad_oe  out  1  AD bus output enable
- ad_i  in  DW  AD bus sampled value
- addr_hi  out  AW-DW  upper address lines, non-multiplexed
- ale  out  1  address latch enable, active high; latches are transparent while high
- oe_n  out  1  read strobe
- we_n  out  1  write strobe
- cs_n  out  NCS  one-hot-low chip selects
- be_n  out  DW/8  byte enables, active low
- bus_wait_n  in  1  external wait; present only with MUX_BUS_EXT_WAIT_EN

## Operation
- States: IDLE, ADDR, HOLD, DATA, RECOV.
- IDLE: req_ready = 1. When req_valid is high, latch we/addr/wdata/be and go to ADDR.
- ADDR (1 cycle): ale = 1; ad_oe = 1; ad_o = addr[DW-1:0]; addr_hi, cs_n and be_n driven.
- HOLD (1 cycle): ale = 0; address still driven on AD; this is the latch hold time.
- DATA (WAIT_CYC+1 cycles):
  - Read: ad_oe = 0 and oe_n = 0.
  - Write: ad_oe = 1, ad_o = wdata and we_n = 0.
- DATA exit: the wait counter loads WAIT_CYC on entry and the state exits when the counter reaches 0.
- RECOV (1 cycle): oe_n, we_n and cs_n deasserted.
  - Write: data remains driven for hold time.
  - Read: ad_oe = 0 for turnaround.
  - rsp_valid = 1.
- Chip-select decode: cs index = req_addr[AW-1 -: log2(NCS)]; exactly one cs_n bit is low from ADDR through DATA.
- Read capture: ad_i is registered into rsp_rdata on the final DATA clock edge. For writes rsp_rdata is unchanged.
- Requests presented outside IDLE are not accepted (req_ready = 0). Inputs are ignored until IDLE.
- Reset values: state IDLE, req_ready 1, ale 0, ad_oe 0, ad_o 0, oe_n 1, we_n 1, cs_n all 1, be_n all 1, addr_hi 0, rsp_valid 0, rsp_rdata 0.
- Reset mid-transaction: all strobes deasserted immediately (asynchronous); no response is produced.

## Timing
- All outputs are registered; no combinational path from request inputs to bus pins.
- Accept edge t0:
  - ADDR is cycle t0+1 and HOLD is t0+2.
  - DATA runs from t0+3 to t0+3+WAIT_CYC.
  - RECOV, with rsp_valid high, is t0+4+WAIT_CYC.
- Next accept is possible at the edge ending RECOV+1 (IDLE). Minimum period is WAIT_CYC+5 cycles per transaction.
- WAIT_CYC = 0: DATA lasts exactly 1 cycle.
- ale and oe_n/we_n never overlap. ad_oe is never high while oe_n is low.

## Configuration
- MUX_BUS_EXT_WAIT_EN defined:
  - bus_wait_n port exists.
  - Once the wait counter is 0, DATA is extended while bus_wait_n = 0, sampled at each rising edge.
  - Read data is captured at the edge where bus_wait_n = 1 is sampled.
- Undefined: the port is absent and the DATA length is fixed at WAIT_CYC+1.

## Structure
- Package mux_bus_pkg: state enum, CS index width function (clog2 of NCS), state encoding constants.
- Sub-module mux_bus_wait_ctr: loadable 4-bit down counter with zero flag. It also qualifies bus_wait_n when the macro is enabled.
- FSM, address/data registers and chip-select decode stay in mux_bus_ctrl.

## Test plan
- Read, WAIT_CYC=1, addr 0x00012 with ad_i=0xBEEF during DATA -> ale high exactly 1 cycle with ad_o=0x0012; cs_n=0xFE; rsp_valid at t0+5; rsp_rdata=0xBEEF.
- Write, addr 0xE0034, wdata 0x1234, be 2'b01:
  - cs_n=0x7F; be_n=2'b10.
  - we_n low 2 cycles with ad_o=0x1234.
  - ad_oe high through RECOV, low in IDLE.
- Back-to-back: req_valid held high for two requests -> second accepted exactly 6 cycles after the first (WAIT_CYC=1); req_ready low in between.
- WAIT_CYC=0 -> DATA 1 cycle; rsp_valid at t0+4.
- rst_n pulsed low during DATA of a write -> we_n, cs_n and ad_oe deasserted without waiting for a clock edge; no rsp_valid; next request runs normally.
- With MUX_BUS_EXT_WAIT_EN, bus_wait_n low for 3 cycles -> DATA stretched by 3; rdata captured on release; rsp_valid one cycle later.

Source files
------------

// File: rtl/mux_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_bus_pkg : state encoding and helpers for the multiplexed bus ctrl    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mux_bus_pkg;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ADDR_ENC  = 3'd1;
  localparam logic [2:0] ST_HOLD_ENC  = 3'd2;
  localparam logic [2:0] ST_DATA_ENC  = 3'd3;
  localparam logic [2:0] ST_RECOV_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ADDR  = ST_ADDR_ENC,
    ST_HOLD  = ST_HOLD_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_RECOV = ST_RECOV_ENC
  } state_t;

  function automatic int cs_idx_w(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_bus_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_bus_ctrl_if : core-side request/response handshake                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mux_bus_ctrl_if #(
  parameter int AW = 20,
  parameter int DW = 16
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_be;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mux_bus_wait_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_bus_wait_ctr : 4-bit loadable down counter with zero flag and        |
// | external-wait qualification (MUX_BUS_EXT_WAIT_EN).  Rev 1.0              |
// +--------------------------------------------------------------------------+
module mux_bus_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
`ifdef MUX_BUS_EXT_WAIT_EN
  input  logic       bus_wait_n,
`endif
  output logic       zero,
  output logic       wait_ok
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

`ifdef MUX_BUS_EXT_WAIT_EN
  assign wait_ok = bus_wait_n;
`else
  assign wait_ok = 1'b1;
`endif

endmodule
`default_nettype wire

// File: rtl/mux_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_bus_ctrl : ALE/OE/WE sequencer for a multiplexed address/data bus;   |
// | optional external wait via MUX_BUS_EXT_WAIT_EN.  Rev 1.0                 |
// +--------------------------------------------------------------------------+
module mux_bus_ctrl
  import mux_bus_pkg::*;
#(
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int NCS      = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_bus_ctrl_if.slave     core,
  output logic [DW-1:0]     ad_o,
  output logic              ad_oe,
  input  logic [DW-1:0]     ad_i,
  output logic [AW-DW-1:0]  addr_hi,
  output logic              ale,
  output logic              oe_n,
  output logic              we_n,
  output logic [NCS-1:0]    cs_n,
  output logic [DW/8-1:0]   be_n
`ifdef MUX_BUS_EXT_WAIT_EN
  ,
  input  logic              bus_wait_n
`endif
);

  localparam int         CSW     = cs_idx_w(NCS);
  localparam int         BW      = DW / 8;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t           state, state_nxt;
  logic             accept, cnt_zero, wait_ok;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [BW-1:0]    be_q;
  logic             ready_q, rsp_valid_q;
  logic [DW-1:0]    rdata_q;

  logic             n_we;
  logic [AW-1:0]    n_addr;
  logic [DW-1:0]    n_wdata;
  logic [BW-1:0]    n_be;
  logic [CSW-1:0]   cs_sel;
  logic [NCS-1:0]   cs_dec;

  logic             nx_ale, nx_ad_oe, nx_oe_n, nx_we_n, nx_rsp;
  logic [DW-1:0]    nx_ad_o;
  logic [AW-DW-1:0] nx_addr_hi;
  logic [NCS-1:0]   nx_cs_n;
  logic [BW-1:0]    nx_be_n;

  mux_bus_wait_ctr u_wait_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == ST_HOLD),
    .dec        (state == ST_DATA),
    .load_val   (WAIT_LD),
`ifdef MUX_BUS_EXT_WAIT_EN
    .bus_wait_n (bus_wait_n),
`endif
    .zero       (cnt_zero),
    .wait_ok    (wait_ok)
  );

  assign accept = (state == ST_IDLE) && core.req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (core.req_valid) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_HOLD;
      ST_HOLD:  state_nxt = ST_DATA;
      ST_DATA:  if (cnt_zero && wait_ok) state_nxt = ST_RECOV;
      ST_RECOV: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state, so the accepting edge already
  // needs the incoming request fields rather than the (not yet loaded) copies.
  always_comb begin
    n_we    = accept ? core.req_we    : we_q;
    n_addr  = accept ? core.req_addr  : addr_q;
    n_wdata = accept ? core.req_wdata : wdata_q;
    n_be    = accept ? core.req_be    : be_q;
    cs_sel  = n_addr[AW-1 -: CSW];
    cs_dec  = ~(NCS'(1) << cs_sel);

    nx_ale     = 1'b0;
    nx_ad_oe   = 1'b0;
    nx_ad_o    = ad_o;
    nx_oe_n    = 1'b1;
    nx_we_n    = 1'b1;
    nx_cs_n    = '1;
    nx_be_n    = '1;
    nx_addr_hi = addr_hi;
    nx_rsp     = 1'b0;
    case (state_nxt)
      ST_ADDR, ST_HOLD: begin
        nx_ale     = (state_nxt == ST_ADDR);
        nx_ad_oe   = 1'b1;
        nx_ad_o    = n_addr[DW-1:0];
        nx_addr_hi = n_addr[AW-1:DW];
        nx_cs_n    = cs_dec;
        nx_be_n    = ~n_be;
      end
      ST_DATA: begin
        nx_addr_hi = n_addr[AW-1:DW];
        nx_cs_n    = cs_dec;
        nx_be_n    = ~n_be;
        if (n_we) begin
          nx_ad_oe = 1'b1;
          nx_ad_o  = n_wdata;
          nx_we_n  = 1'b0;
        end else begin
          nx_oe_n  = 1'b0;
        end
      end
      ST_RECOV: begin
        nx_rsp = 1'b1;
        if (n_we) begin
          nx_ad_oe = 1'b1;
          nx_ad_o  = n_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ale         <= 1'b0;
      ad_oe       <= 1'b0;
      ad_o        <= '0;
      oe_n        <= 1'b1;
      we_n        <= 1'b1;
      cs_n        <= '1;
      be_n        <= '1;
      addr_hi     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= core.req_we;
        addr_q  <= core.req_addr;
        wdata_q <= core.req_wdata;
        be_q    <= core.req_be;
      end
      ale         <= nx_ale;
      ad_oe       <= nx_ad_oe;
      ad_o        <= nx_ad_o;
      oe_n        <= nx_oe_n;
      we_n        <= nx_we_n;
      cs_n        <= nx_cs_n;
      be_n        <= nx_be_n;
      addr_hi     <= nx_addr_hi;
      ready_q     <= (state_nxt == ST_IDLE);
      rsp_valid_q <= nx_rsp;
      if ((state == ST_DATA) && (state_nxt == ST_RECOV) && !we_q) begin
        rdata_q <= ad_i;
      end
    end
  end

  assign core.req_ready = ready_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_bus_ctrl : vector table, corner sequences and random transactions |
// | for mux_bus_ctrl (WAIT_CYC=1 and WAIT_CYC=0 instances).  Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_mux_bus_ctrl;
  import mux_bus_pkg::*;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_bus_ctrl_if #(.AW(20), .DW(16)) bus  ();
  mux_bus_ctrl_if #(.AW(20), .DW(16)) bus0 ();

  logic [15:0] ad_o, ad_i, d0_ad_o, d0_ad_i;
  logic        ad_oe, ale, oe_n, we_n, d0_ad_oe, d0_ale, d0_oe_n, d0_we_n;
  logic [3:0]  addr_hi, d0_addr_hi;
  logic [7:0]  cs_n, d0_cs_n;
  logic [1:0]  be_n, d0_be_n;
`ifdef MUX_BUS_EXT_WAIT_EN
  logic        bus_wait_n;
`endif

  mux_bus_ctrl #(.AW(20), .DW(16), .NCS(8), .WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n), .core(bus),
    .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i), .addr_hi(addr_hi),
    .ale(ale), .oe_n(oe_n), .we_n(we_n), .cs_n(cs_n), .be_n(be_n)
`ifdef MUX_BUS_EXT_WAIT_EN
    , .bus_wait_n(bus_wait_n)
`endif
  );

  mux_bus_ctrl #(.AW(20), .DW(16), .NCS(8), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .core(bus0),
    .ad_o(d0_ad_o), .ad_oe(d0_ad_oe), .ad_i(d0_ad_i), .addr_hi(d0_addr_hi),
    .ale(d0_ale), .oe_n(d0_oe_n), .we_n(d0_we_n), .cs_n(d0_cs_n), .be_n(d0_be_n)
`ifdef MUX_BUS_EXT_WAIT_EN
    , .bus_wait_n(1'b1)
`endif
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [15:0] model_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] cs_of(input logic [19:0] a);
    int idx;
    logic [7:0] one;
    idx = int'(a) / (1 << 17);
    one = 8'd1;
    return ~(one << idx);
  endfunction

  // Expected pins per cycle follow purely from the cycle offset after accept:
  // 1 ADDR, 2 HOLD, 3..2+L DATA, 3+L RECOV, 4+L IDLE.
  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] rd, input int stretch,
                         input logic [7:0] exp_cs, input logic [1:0] exp_ben);
    int L;
    logic [5:0] exp_ctl, act_ctl;
    logic in_data;
    L = W + 1 + stretch;
    chk("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_be = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_addr = 20'($urandom);
    bus.req_wdata = 16'($urandom); bus.req_be = 2'($urandom);
    for (int n = 1; n <= L + 4; n++) begin
      in_data = (n >= 3) && (n < 3 + L);
      ad_i = (n == 2 + L) ? rd : ~rd;
`ifdef MUX_BUS_EXT_WAIT_EN
      bus_wait_n = !(in_data && (n - 3) >= W && (n - 3) < W + stretch);
`endif
      if (n == 1)          exp_ctl = 6'b111100;
      else if (n == 2)     exp_ctl = 6'b011100;
      else if (in_data)    exp_ctl = we ? 6'b011000 : 6'b000100;
      else if (n == 3 + L) exp_ctl = {1'b0, we, 4'b1110};
      else                 exp_ctl = 6'b001101;
      act_ctl = {ale, ad_oe, oe_n, we_n, bus.rsp_valid, bus.req_ready};
      chk($sformatf("ctl[n=%0d]", n), 32'(act_ctl), 32'(exp_ctl));
      chk($sformatf("cs_n[n=%0d]", n), 32'(cs_n), 32'((n < 3 + L) ? exp_cs : 8'hFF));
      if (n < 3 + L) begin
        chk($sformatf("be_n[n=%0d]", n), 32'(be_n), 32'(exp_ben));
        chk($sformatf("addr_hi[n=%0d]", n), 32'(addr_hi), 32'(addr[19:16]));
      end
      if (n <= 2) chk($sformatf("ad_o_addr[n=%0d]", n), 32'(ad_o), 32'(addr[15:0]));
      else if (we && n <= 3 + L) chk($sformatf("ad_o_wd[n=%0d]", n), 32'(ad_o), 32'(wd));
      if (n == 3 + L) begin
        if (!we) model_rdata = rd;
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(model_rdata));
      end
      if (n < L + 4) begin
        @(posedge clk); #1;
      end
    end
`ifdef MUX_BUS_EXT_WAIT_EN
    bus_wait_n = 1'b1;
`endif
  endtask

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] rd;
    logic [7:0]  exp_cs;
    logic [1:0]  exp_ben;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    logic [1:0]  b;
    logic        w;
    int          st;

    tbl[0] = '{1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBEEF, 8'hFE, 2'b00, 16'hBEEF};
    tbl[1] = '{1'b1, 20'hE0034, 16'h1234, 2'b01, 16'h0000, 8'h7F, 2'b10, 16'hBEEF};
    tbl[2] = '{1'b0, 20'h6ABCD, 16'h0000, 2'b10, 16'h0F0F, 8'hF7, 2'b01, 16'h0F0F};
    tbl[3] = '{1'b1, 20'hA0000, 16'hFFFF, 2'b10, 16'h0000, 8'hDF, 2'b01, 16'h0F0F};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_be = '0;
    ad_i = '0; d0_ad_i = '0;
`ifdef MUX_BUS_EXT_WAIT_EN
    bus_wait_n = 1'b1;
`endif
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({ale, ad_oe, oe_n, we_n, bus.rsp_valid, bus.req_ready}), 32'(6'b001101));
    chk("rst_ad_o", 32'(ad_o), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hFF);
    chk("rst_be_n", 32'(be_n), 32'h3);
    chk("rst_addr_hi", 32'(addr_hi), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYC=0 instance: one DATA cycle, response at t0+4
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 20'h20056; bus0.req_be = 2'b11;
    d0_ad_i = 16'h5A5A;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      chk($sformatf("w0_oe_n[e=%0d]", e), 32'(d0_oe_n), 32'(e != 2));
      chk($sformatf("w0_rsp[e=%0d]", e), 32'(bus0.rsp_valid), 32'(e == 3));
      if (e == 0) chk("w0_cs_n", 32'(d0_cs_n), 32'hFD);
      if (e == 3) chk("w0_rdata", 32'(bus0.rsp_rdata), 32'h5A5A);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 4; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].rd, 0,
              tbl[i].exp_cs, tbl[i].exp_ben);
      chk($sformatf("tbl_rdata[%0d]", i), 32'(bus.rsp_rdata), 32'(tbl[i].exp_rdata));
    end

    // Back-to-back with req_valid held high: second accept 6 edges later
    ad_i = 16'h7777;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 20'h40000;
    bus.req_wdata = 16'hAAAA; bus.req_be = 2'b11;
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_addr = 20'h80000;
    for (int e = 0; e <= 6; e++) begin
      chk($sformatf("b2b_ready[e=%0d]", e), 32'(bus.req_ready), 32'(e == 5));
      chk($sformatf("b2b_ale[e=%0d]", e), 32'(ale), 32'(e == 0 || e == 6));
      if (e == 0) chk("b2b_cs_a", 32'(cs_n), 32'hFB);
      if (e == 6) chk("b2b_cs_b", 32'(cs_n), 32'hEF);
      if (e < 6) begin
        @(posedge clk); #1;
      end
    end
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_rdata = 16'h7777;
    chk("b2b_rdata", 32'(bus.rsp_rdata), 32'(model_rdata));
    chk("b2b_ready_end", 32'(bus.req_ready), 32'd1);

    // Asynchronous reset during the DATA phase of a write
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 20'hC0010;
    bus.req_wdata = 16'h55AA; bus.req_be = 2'b11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_pre_we_n", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", 32'({we_n, ad_oe, ale}), 32'(3'b100));
    chk("arst_cs_n", 32'(cs_n), 32'hFF);
    #2 rst_n = 1'b1;
    model_rdata = '0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      chk($sformatf("arst_no_rsp[e=%0d]", e), 32'(bus.rsp_valid), 32'd0);
    end
    chk("arst_ready", 32'(bus.req_ready), 32'd1);
    run_txn(1'b0, 20'hC0010, 16'h0, 2'b11, 16'hC3C3, 0, 8'hBF, 2'b00);

`ifdef MUX_BUS_EXT_WAIT_EN
    run_txn(1'b0, 20'h2FFFE, 16'h0, 2'b11, 16'h9876, 3, 8'hFD, 2'b00);
    run_txn(1'b1, 20'h2FFFE, 16'h4321, 2'b10, 16'h0, 2, 8'hFD, 2'b01);
`endif

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rand_gap_ready", 32'(bus.req_ready), 32'd1);
      end
      a  = 20'($urandom);
      b  = 2'($urandom);
      w  = 1'($urandom);
`ifdef MUX_BUS_EXT_WAIT_EN
      st = int'($urandom_range(0, 2));
`else
      st = 0;
`endif
      run_txn(w, a, 16'($urandom), b, 16'($urandom), st, cs_of(a), ~b);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
